// File: rtl/sysid_checker_if.sv
// Avalon-MM read-only bus between the system-ID checker (master) and the
// system-ID slave. Only the signals the checker needs are carried.
interface sysid_checker_if;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;

   modport master (
      output avm_address,
      output avm_read,
      input  avm_waitrequest,
      input  avm_readdata
   );

   modport slave (
      input  avm_address,
      input  avm_read,
      output avm_waitrequest,
      output avm_readdata
   );
endinterface

// File: rtl/sysid_checker.sv
// sysid_checker: reads the ID word (address 0) and the timestamp word
// (address 1) from the system-ID slave, compares them against the expected
// image values and reports pass/fail plus the captured words.
// Optional feature macro: SYSID_CHECKER_RETRY_EN -- on a mismatch or timeout
// the check is retried up to 3 times before done is pulsed, and a
// retry_count output is added.
module sysid_checker #(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1487599541,
   parameter int unsigned READ_LATENCY   = 0,     // 0..3
   parameter int unsigned TIMEOUT_CYCLES = 255,   // 1..65535
   parameter bit          AUTO_START     = 1'b1
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            start,
   sysid_checker_if.master avm,
   output logic            busy,
   output logic            done,
   output logic            id_ok,
   output logic            ts_ok,
   output logic            timeout,
   output logic [31:0]     id_value,
   output logic [31:0]     ts_value
`ifdef SYSID_CHECKER_RETRY_EN
   ,
   output logic [1:0]      retry_count
`endif
);

   typedef enum logic [2:0] {IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, FIN} state_t;

   localparam logic [15:0] TMO_LIMIT = 16'(TIMEOUT_CYCLES);
   localparam logic [1:0]  LAT_LAST  = (READ_LATENCY == 0) ? 2'd0 : 2'(READ_LATENCY - 1);

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        id_ok_q, id_ok_d;
   logic        ts_ok_q, ts_ok_d;
   logic        timeout_q, timeout_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;
   logic        id_got_q, id_got_d;     // word actually captured this attempt
   logic        ts_got_q, ts_got_d;
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic [15:0] tmo_cnt_q, tmo_cnt_d;
   logic        auto_q, auto_d;         // pending automatic check after reset
`ifdef SYSID_CHECKER_RETRY_EN
   logic [1:0]  retry_q, retry_d;
`endif
   logic        read_c, addr_c;
   logic        id_match, ts_match;

   // Next-state and bus-output logic of the check sequencer.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d    = state_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      id_ok_d    = id_ok_q;
      ts_ok_d    = ts_ok_q;
      timeout_d  = timeout_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;
      id_got_d   = id_got_q;
      ts_got_d   = ts_got_q;
      lat_cnt_d  = lat_cnt_q;
      tmo_cnt_d  = tmo_cnt_q;
      auto_d     = 1'b0;
`ifdef SYSID_CHECKER_RETRY_EN
      retry_d    = retry_q;
`endif
      read_c     = 1'b0;
      addr_c     = 1'b0;
      id_match   = 1'b0;
      ts_match   = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start || auto_q) begin
               state_d   = RD_ID;
               busy_d    = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
               id_got_d  = 1'b0;
               ts_got_d  = 1'b0;
               tmo_cnt_d = '0;
`ifdef SYSID_CHECKER_RETRY_EN
               retry_d   = 2'd0;
`endif
            end
         end

         RD_ID, RD_TS: begin
            read_c = 1'b1;
            addr_c = (state_q == RD_TS);
            if (!avm.avm_waitrequest) begin
               tmo_cnt_d = '0;
               if (READ_LATENCY == 0) begin
                  // Zero-latency slave: data is valid in the accept cycle.
                  if (state_q == RD_ID) begin
                     id_value_d = avm.avm_readdata;
                     id_got_d   = 1'b1;
                     state_d    = RD_TS;
                  end else begin
                     ts_value_d = avm.avm_readdata;
                     ts_got_d   = 1'b1;
                     state_d    = FIN;
                  end
               end else begin
                  lat_cnt_d = '0;
                  state_d   = (state_q == RD_ID) ? LAT_ID : LAT_TS;
               end
            end else begin
               if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 16'd1;
               if (tmo_cnt_d >= TMO_LIMIT) begin
                  timeout_d = 1'b1;
                  tmo_cnt_d = '0;
                  state_d   = FIN;
               end
            end
         end

         LAT_ID, LAT_TS: begin
            if (lat_cnt_q == LAT_LAST) begin
               lat_cnt_d = '0;
               if (state_q == LAT_ID) begin
                  id_value_d = avm.avm_readdata;
                  id_got_d   = 1'b1;
                  state_d    = RD_TS;
               end else begin
                  ts_value_d = avm.avm_readdata;
                  ts_got_d   = 1'b1;
                  state_d    = FIN;
               end
            end else begin
               lat_cnt_d = lat_cnt_q + 2'd1;
            end
         end

         FIN: begin
            // A word that was never captured (timeout) can never match.
            id_match = id_got_q && (id_value_q == EXPECTED_ID);
            ts_match = ts_got_q && (ts_value_q == EXPECTED_TS);
            id_ok_d  = id_match;
            ts_ok_d  = ts_match;
            done_d   = 1'b1;
            busy_d   = 1'b0;
            state_d  = IDLE;
`ifdef SYSID_CHECKER_RETRY_EN
            if (!(id_match && ts_match) && (retry_q != 2'd3)) begin
               retry_d   = retry_q + 2'd1;
               done_d    = 1'b0;
               busy_d    = 1'b1;
               id_ok_d   = 1'b0;
               ts_ok_d   = 1'b0;
               timeout_d = 1'b0;
               id_got_d  = 1'b0;
               ts_got_d  = 1'b0;
               state_d   = RD_ID;
            end
`endif
         end

         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous active-low reset.
   always_ff @(posedge clock) begin
      // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
      if (!reset_n) begin
         // NOTE: the captured words are reset as well because they drive outputs that must read 0 in reset.
         state_q    <= IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         id_ok_q    <= 1'b0;
         ts_ok_q    <= 1'b0;
         timeout_q  <= 1'b0;
         id_value_q <= '0;
         ts_value_q <= '0;
         id_got_q   <= 1'b0;
         ts_got_q   <= 1'b0;
         lat_cnt_q  <= '0;
         tmo_cnt_q  <= '0;
         auto_q     <= AUTO_START;
`ifdef SYSID_CHECKER_RETRY_EN
         retry_q    <= '0;
`endif
      end else begin
         state_q    <= state_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         id_ok_q    <= id_ok_d;
         ts_ok_q    <= ts_ok_d;
         timeout_q  <= timeout_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
         id_got_q   <= id_got_d;
         ts_got_q   <= ts_got_d;
         lat_cnt_q  <= lat_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         auto_q     <= auto_d;
`ifdef SYSID_CHECKER_RETRY_EN
         retry_q    <= retry_d;
`endif
      end
   end

   assign avm.avm_read    = read_c;
   assign avm.avm_address = addr_c;
   assign busy            = busy_q;
   assign done            = done_q;
   assign id_ok           = id_ok_q;
   assign ts_ok           = ts_ok_q;
   assign timeout         = timeout_q;
   assign id_value        = id_value_q;
   assign ts_value        = ts_value_q;
`ifdef SYSID_CHECKER_RETRY_EN
   assign retry_count     = retry_q;
`endif

endmodule
